// File: rtl/fm_phase_accumulator_if.sv
// fm_phase_accumulator_if: config handshake, Morse key and phase outputs of the FM NCO
interface fm_phase_accumulator_if #(
  parameter int PHASE_BITS = 32,
  parameter int OUT_BITS = 16,
  parameter int TONE_BITS = 24,
  parameter int DEV_BITS = 24
);
  logic cfg_valid;
  logic cfg_ready;
  logic [PHASE_BITS-1:0] cfg_carrier;
  logic [TONE_BITS-1:0] cfg_tone;
  logic [DEV_BITS-1:0] cfg_dev;
  logic key;
  logic [OUT_BITS-1:0] phase_out;
  logic phase_valid;
  logic keyed;
  modport master(
    output cfg_valid, cfg_carrier, cfg_tone, cfg_dev, key,
    input cfg_ready, phase_out, phase_valid, keyed
  );
  modport slave(
    input cfg_valid, cfg_carrier, cfg_tone, cfg_dev, key,
    output cfg_ready, phase_out, phase_valid, keyed
  );
endinterface

// File: rtl/fm_phase_accumulator.sv
// fm_phase_accumulator: FM Morse NCO phase generator; define TRIANGLE_MOD_EN for triangle instead of square tone modulation
module fm_phase_accumulator #(
  parameter int PHASE_BITS = 32,
  parameter int OUT_BITS = 16,
  parameter int TONE_BITS = 24,
  parameter int DEV_BITS = 24
) (
  input logic clk,
  input logic rst,
  fm_phase_accumulator_if.slave bus
);
  typedef enum logic {IDLE, PENDING} stateT;
  stateT state, nextState;
  logic [PHASE_BITS-1:0] shadowCarrier, activeCarrier, freqWord, phaseAcc, offset;
  logic [TONE_BITS-1:0] shadowTone, activeTone, toneAcc;
  logic [DEV_BITS-1:0] shadowDev, activeDev;
  logic accept, apply;
  always_comb begin
    accept = state == IDLE && bus.cfg_valid;
    apply = state == PENDING && !bus.key;
    nextState = accept ? PENDING : apply ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      phaseAcc <= '0;
      {shadowCarrier, shadowTone, shadowDev} <= '0;
      {activeCarrier, activeTone, activeDev} <= '0;
    end else begin
      state <= nextState;
      phaseAcc <= phaseAcc + freqWord;
      if (accept) {shadowCarrier, shadowTone, shadowDev} <= {bus.cfg_carrier, bus.cfg_tone, bus.cfg_dev};
      if (apply) {activeCarrier, activeTone, activeDev} <= {shadowCarrier, shadowTone, shadowDev};
    end
  assign bus.cfg_ready = state == IDLE;
  assign bus.phase_out = phaseAcc[PHASE_BITS-1 -: OUT_BITS];
`ifdef TRIANGLE_MOD_EN
  logic [TONE_BITS-2:0] triVal;
  logic signed [TONE_BITS-1:0] triS;
  logic signed [TONE_BITS+DEV_BITS:0] scaled;
  logic [PHASE_BITS-1:0] offsetR, carrierR;
  logic [1:0] keyedP;
  logic [2:0] vld;
  // triangle centred on zero, scaled so its peak equals the deviation word
  always_comb begin
    triVal = toneAcc[TONE_BITS-1] ? ~toneAcc[TONE_BITS-2:0] : toneAcc[TONE_BITS-2:0];
    triS = $signed({1'b0, triVal}) - $signed(TONE_BITS'(1) << (TONE_BITS-2));
    scaled = (triS * $signed({1'b0, activeDev})) >>> (TONE_BITS-2);
    offset = bus.key ? PHASE_BITS'(scaled) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      offsetR <= '0;
      carrierR <= '0;
      freqWord <= '0;
      toneAcc <= '0;
      keyedP <= '0;
      vld <= '0;
    end else begin
      offsetR <= offset;
      carrierR <= activeCarrier;
      freqWord <= carrierR + offsetR;
      toneAcc <= bus.key ? toneAcc + activeTone : '0;
      keyedP <= {keyedP[0], bus.key};
      vld <= {vld[1:0], 1'b1};
    end
  assign bus.keyed = keyedP[1];
  assign bus.phase_valid = vld[2];
`else
  logic keyedR;
  logic [1:0] vld;
  always_comb offset = bus.key ? (toneAcc[TONE_BITS-1] ? -PHASE_BITS'(activeDev) : PHASE_BITS'(activeDev)) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      freqWord <= '0;
      toneAcc <= '0;
      keyedR <= 1'b0;
      vld <= '0;
    end else begin
      freqWord <= activeCarrier + offset;
      toneAcc <= bus.key ? toneAcc + activeTone : '0;
      keyedR <= bus.key;
      vld <= {vld[0], 1'b1};
    end
  assign bus.keyed = keyedR;
  assign bus.phase_valid = vld[1];
`endif
endmodule

// File: tb/tb_fm_phase_accumulator.sv
// tb_fm_phase_accumulator: scoreboard bench checking per-clock phase steps and handshake/status flags
module tb_fm_phase_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fm_phase_accumulator_if bus();
  fm_phase_accumulator dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {bit chk; logic [15:0] step;} expT;
  expT q[$];
  int checks = 0;
  int fails = 0;
  logic [15:0] prev = '0;
  logic [15:0] step;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input int n, input bit chk, input logic [15:0] s);
    for (int i = 0; i < n; i++) q.push_back('{chk, s});
  endtask
  task automatic tick();
    expT e;
    @(posedge clk);
    #1;
    step = bus.phase_out - prev;
    prev = bus.phase_out;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) check("step", {16'h0, step}, {16'h0, e.step});
    end
  endtask
  task automatic drain();
    while (q.size() > 0) tick();
  endtask
  task automatic apply_cfg(input logic [31:0] c, input logic [23:0] t, input logic [23:0] d, input logic [15:0] base);
    push(3, 0, '0);
    push(3, 1, base);
    bus.cfg_valid = 1'b1;
    bus.cfg_carrier = c;
    bus.cfg_tone = t;
    bus.cfg_dev = d;
    tick();
    check("ready_low", {31'h0, bus.cfg_ready}, 0);
    bus.cfg_valid = 1'b0;
    tick();
    check("ready_back", {31'h0, bus.cfg_ready}, 1);
    drain();
  endtask
  task automatic keyed_burst(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] base);
    bus.key = 1'b1;
    push(1, 0, '0);
    push(8, 1, hi);
    push(8, 1, lo);
    tick();
    check("keyed_on", {31'h0, bus.keyed}, 1);
    drain();
    bus.key = 1'b0;
    push(1, 1, hi);
    push(2, 1, base);
    tick();
    check("keyed_off", {31'h0, bus.keyed}, 0);
    drain();
  endtask
  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_carrier = '0;
    bus.cfg_tone = '0;
    bus.cfg_dev = '0;
    bus.key = 1'b0;
    repeat (3) tick();
    check("rst_phase", {16'h0, bus.phase_out}, 0);
    check("rst_valid", {31'h0, bus.phase_valid}, 0);
    check("rst_keyed", {31'h0, bus.keyed}, 0);
    rst = 1'b0;
    tick();
    check("valid_1clk", {31'h0, bus.phase_valid}, 0);
    check("ready_init", {31'h0, bus.cfg_ready}, 1);
    tick();
    check("valid_2clk", {31'h0, bus.phase_valid}, 1);
    apply_cfg(32'h0100_0000, 24'h0, 24'h0, 16'h0100);
    push(253, 1, 16'h0100);
    drain();
    check("wrap_zero", {16'h0, bus.phase_out}, 0);
    apply_cfg(32'h0100_0000, 24'h10_0000, 24'h10_0000, 16'h0100);
    keyed_burst(16'h0110, 16'h00F0, 16'h0100);
    bus.key = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_carrier = 32'h0200_0000;
    push(1, 1, 16'h0100);
    push(8, 1, 16'h0110);
    push(3, 1, 16'h00F0);
    tick();
    check("pend_ready", {31'h0, bus.cfg_ready}, 0);
    bus.cfg_carrier = 32'h0300_0000;
    drain();
    check("pend_hold_ready", {31'h0, bus.cfg_ready}, 0);
    bus.cfg_valid = 1'b0;
    bus.key = 1'b0;
    push(1, 1, 16'h00F0);
    push(1, 1, 16'h0100);
    push(4, 1, 16'h0200);
    tick();
    check("apply_ready", {31'h0, bus.cfg_ready}, 1);
    drain();
    apply_cfg(32'h0008_0000, 24'h10_0000, 24'h10_0000, 16'h0008);
    keyed_burst(16'h0018, 16'hFFF8, 16'h0008);
    apply_cfg(32'hFFF8_0000, 24'h10_0000, 24'h10_0000, 16'hFFF8);
    keyed_burst(16'h0008, 16'hFFE8, 16'hFFF8);
    bus.key = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_carrier = 32'h0500_0000;
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    check("rst_pend_ready", {31'h0, bus.cfg_ready}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.key = 1'b0;
    check("mid_rst_phase", {16'h0, bus.phase_out}, 0);
    check("mid_rst_keyed", {31'h0, bus.keyed}, 0);
    check("mid_rst_valid", {31'h0, bus.phase_valid}, 0);
    check("mid_rst_ready", {31'h0, bus.cfg_ready}, 1);
    push(4, 1, 16'h0000);
    tick();
    check("mid_valid_1clk", {31'h0, bus.phase_valid}, 0);
    drain();
    check("mid_valid_after", {31'h0, bus.phase_valid}, 1);
    apply_cfg(32'h0300_0000, 24'h0, 24'h0, 16'h0300);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
